// File: rtl/div_issue_pkg.sv
// Shared handshake constants and state encoding for the divide issue/collect controller.
package div_issue_pkg;

    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
    localparam int          CNT_W                = 6;

    typedef enum logic {
        DIV_ISSUE_IDLE = 1'b0,
        DIV_ISSUE_WAIT = 1'b1
    } div_state_t;

endpackage

// File: rtl/div_issue.sv
// EX-stage divide issue/collect: launches the multi-cycle divider, stalls the
// pipeline until it is ready, then emits a single HI/LO write.
//
// state          | meaning
// DIV_ISSUE_IDLE | no divide in flight; a request issues this cycle
// DIV_ISSUE_WAIT | divider running; operands held, stall raised
module div_issue
    import div_issue_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    div_state_t       state_q, state_d;
    logic [31:0]      op1_q, op2_q;
    logic             sgn_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             load;

    always_comb begin
        state_d     = state_q;
        div_start_o = DIV_STOP;
        div_annul_o = 1'b0;
        stallreq_o  = 1'b0;
        whilo_o     = 1'b0;
        load        = 1'b0;
        case (state_q)
            DIV_ISSUE_IDLE: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                end else if (div_req_i) begin
                    div_start_o = DIV_START;
                    stallreq_o  = 1'b1;
                    load        = 1'b1;
                    state_d     = DIV_ISSUE_WAIT;
                end
            end
            DIV_ISSUE_WAIT: begin
                // Flush beats a simultaneous ready: the killed instruction must not write HI/LO.
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = DIV_ISSUE_IDLE;
                end else if (div_ready_i == DIV_RESULT_READY) begin
                    whilo_o = 1'b1;
                    state_d = DIV_ISSUE_IDLE;
                end else begin
                    div_start_o = DIV_START;
                    stallreq_o  = 1'b1;
                end
            end
            default: state_d = DIV_ISSUE_IDLE;
        endcase
        if (rst) begin
            div_start_o = DIV_STOP;
            div_annul_o = 1'b0;
            stallreq_o  = 1'b0;
            whilo_o     = 1'b0;
            load        = 1'b0;
        end
    end

    // Issue cycle forwards live operands; afterwards the held copies feed the divider.
    assign div_op1_o    = load ? op1_i    : op1_q;
    assign div_op2_o    = load ? op2_i    : op2_q;
    assign div_signed_o = load ? signed_i : sgn_q;

    assign hi_o  = whilo_o ? div_result_i[63:32] : ZERO_WORD;
    assign lo_o  = whilo_o ? div_result_i[31:0]  : ZERO_WORD;
    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_ISSUE_IDLE;
            op1_q   <= ZERO_WORD;
            op2_q   <= ZERO_WORD;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op1_q <= op1_i;
                op2_q <= op2_i;
                sgn_q <= signed_i;
                cnt_q <= '0;
            end else if (state_q == DIV_ISSUE_WAIT && !flush_i &&
                         div_ready_i == DIV_RESULT_NOT_READY && cnt_q != TIMEOUT_CNT) begin
                // Saturates at TIMEOUT so a hung divider cannot wrap the counter.
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q + 1'b1 == TIMEOUT_CNT)
                    err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural divider (35-cycle latency,
// 3 cycles for a zero divisor) and hand-computed HI/LO expectations.
module tb_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req_i, signed_i, flush_i;
    logic [31:0] op1_i, op2_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stallreq_o, whilo_o, err_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int exp_pulses = 0;

    logic never_ready = 1'b0;
    logic force_ready = 1'b0;
    logic m_busy;
    int   m_cyc, m_lat;
    logic signed [31:0] m_q, m_r;

    div_issue #(.TIMEOUT(40)) dut (
        .clk(clk), .rst(rst), .div_req_i(div_req_i), .signed_i(signed_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Divider model: latches start, counts, holds ready until start drops.
    always @(posedge clk) begin
        if (rst || div_annul_o) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            m_lat  <= 0;
        end else if (!m_busy && div_start_o) begin
            m_busy <= 1'b1;
            m_cyc  <= 1;
            m_lat  <= (div_op2_o == 32'd0) ? 3 : 35;
        end else if (m_busy) begin
            if (!div_start_o) m_busy <= 1'b0;
            else              m_cyc  <= m_cyc + 1;
        end
    end

    assign div_ready_i = force_ready | (m_busy && !never_ready && m_cyc == m_lat);

    always_comb begin
        m_q = '0;
        m_r = '0;
        div_result_i = 64'd0;
        if (force_ready) begin
            div_result_i = 64'hDEAD_BEEF_1234_5678;
        end else if (div_op2_o != 32'd0) begin
            if (div_signed_o) begin
                m_q = $signed(div_op1_o) / $signed(div_op2_o);
                m_r = $signed(div_op1_o) % $signed(div_op2_o);
                div_result_i = {m_r, m_q};
            end else begin
                div_result_i = {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
            end
        end
    end

    always @(negedge clk) if (whilo_o === 1'b1) pulses++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of cycle 0; returns at the start of the cycle after the write.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int lat, input string nm);
        bit bad = 0;
        div_req_i = 1'b1; signed_i = sgn; op1_i = a; op2_i = b;
        @(negedge clk);
        chk({nm, " issue start"}, div_start_o, 1);
        chk({nm, " issue stall"}, stallreq_o, 1);
        chk({nm, " issue whilo"}, whilo_o, 0);
        chk({nm, " issue ops"}, {31'd0, div_signed_o, div_op1_o}, {31'd0, sgn, a});
        step();
        div_req_i = 1'b0; op1_i = $urandom; op2_i = $urandom; signed_i = ~sgn;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            if (stallreq_o !== 1'b1 || div_start_o !== 1'b1 || whilo_o !== 1'b0 ||
                div_op1_o !== a || div_op2_o !== b || div_signed_o !== sgn)
                bad = 1;
            step();
        end
        chk({nm, " wait hold"}, {63'd0, bad}, 0);
        @(negedge clk);
        chk({nm, " whilo"}, whilo_o, 1);
        chk({nm, " hi"}, hi_o, ehi);
        chk({nm, " lo"}, lo_o, elo);
        chk({nm, " stall released"}, {stallreq_o, div_start_o}, 2'b00);
        exp_pulses++;
        step();
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, hi, lo;
        int          lat;
        string       nm;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 35, "div_7_m2"};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 35, "divu_ff_16"};
        tbl[2] = '{1'b1, 32'd5,         32'd0,         32'h0,         32'h0,         3,  "div_by_zero"};
        tbl[3] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 35, "div_m100_7"};
        tbl[4] = '{1'b0, 32'd0,         32'd0,         32'h0,         32'h0,         3,  "divu_0_by_0"};

        rst = 1'b1; div_req_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
        op1_i = '0; op2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset start/annul/stall/whilo", {div_start_o, div_annul_o, stallreq_o, whilo_o}, 4'b0000);
        chk("reset hi/lo", {hi_o, lo_o}, 64'd0);
        chk("reset err", err_o, 0);
        chk("reset ops", {div_op1_o, div_op2_o}, 64'd0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat, tbl[i].nm);
        chk("no err after normal divides", err_o, 0);

        // Back-to-back: second issue lands in cycle 36 of the first.
        run_div(1'b1, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "b2b_m9_4");
        run_div(1'b1, 32'd9,         32'd4, 32'd1,         32'd2,         35, "b2b_9_4");

        // Flush at cycle 10, then DIVU 100/7 issued in cycle 11.
        div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd7; op2_i = 32'hFFFF_FFFE;
        step();
        div_req_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush annul", div_annul_o, 1);
        chk("flush start/stall/whilo", {div_start_o, stallreq_o, whilo_o}, 3'b000);
        step();
        flush_i = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35, "divu_100_7_after_flush");

        // Flush coinciding with ready suppresses the write.
        div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd7; op2_i = 32'hFFFF_FFFE;
        step();
        div_req_i = 1'b0;
        repeat (34) step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush+ready ready seen", div_ready_i, 1);
        chk("flush+ready whilo/annul", {whilo_o, div_annul_o}, 2'b01);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush+ready back idle", {stallreq_o, div_start_o, whilo_o}, 3'b000);
        step();

        // Ready while idle is ignored; flush while idle blocks a request.
        force_ready = 1'b1;
        @(negedge clk);
        chk("idle ready whilo/hi", {31'd0, whilo_o, hi_o}, 64'd0);
        step();
        force_ready = 1'b0;
        div_req_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        chk("idle flush annul/start/stall", {div_annul_o, div_start_o, stallreq_o}, 3'b100);
        step();
        div_req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle flush no issue", {stallreq_o, div_start_o}, 2'b00);
        step();

        // Reset mid-divide: abandoned without a write.
        div_req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd50; op2_i = 32'd3;
        step();
        div_req_i = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        begin
            bit bad = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) bad = 1;
                step();
            end
            chk("mid-divide reset no write", {63'd0, bad}, 0);
        end

        // Hung divider: err after TIMEOUT wait cycles, stall held, rst clears.
        never_ready = 1'b1;
        div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd7; op2_i = 32'd2;
        step();
        div_req_i = 1'b0;
        repeat (34) step();
        @(negedge clk);
        chk("timeout err early", err_o, 0);
        chk("timeout stall early", stallreq_o, 1);
        repeat (10) step();
        @(negedge clk);
        chk("timeout err set", err_o, 1);
        chk("timeout stall held", {stallreq_o, div_start_o}, 2'b11);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; never_ready = 1'b0;
        @(negedge clk);
        chk("timeout rst clears", {err_o, stallreq_o, div_start_o, whilo_o}, 4'b0000);
        step();

        run_div(1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 35, "divu_20_6_after_rst");
        chk("whilo pulse count", pulses, exp_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
